// File: rtl/dvp_pixel_packer.sv
// DVP byte-stream to RGB565 pixel packer. It discards a number of start-up frames,
// then emits pixels with x/y coordinates and line/frame event and error pulses.
module dvp_pixel_packer #(
    parameter int SKIP_FRAMES = 10,
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480
) (
    input  logic        data_clk,
    input  logic        rst_n,
    input  logic        data_href,
    input  logic        data_vsync,
    input  logic [7:0]  source_data,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        frame_start,
    output logic        line_end,
    output logic        frame_done,
    output logic        frame_err,
    output logic        capture_active
);

    localparam logic [8:0]  SKIP_W = 9'(SKIP_FRAMES);
    localparam logic [11:0] H_W    = 12'(H_PIXELS);
    localparam logic [11:0] V_W    = 12'(V_LINES);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        SKIP,
        ACTIVE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  frame_cnt;
    logic [7:0]  frame_cnt_next;

    logic        vsync_d;
    logic        href_d;
    logic        vs_rise;
    logic        href_fall;
    logic        accept;

    logic        byte_phase;
    logic        line_open;
    logic [7:0]  high_byte;
    logic [11:0] pix_cnt;
    logic [11:0] line_cnt;

    logic        line_trunc;
    logic        line_close;
    logic        line_bad;
    logic [11:0] line_cnt_upd;
    logic        frame_close;
    logic        frame_bad;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign vs_rise        = data_vsync & ~vsync_d;
    assign href_fall      = href_d & ~data_href;
    assign accept         = (state == ACTIVE) & data_href & ~data_vsync;
    assign capture_active = (state == ACTIVE);

    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_SYNC;
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            frame_cnt <= frame_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        frame_cnt_next = frame_cnt;
        case (state)
            WAIT_SYNC: begin
                if (vs_rise) begin
                    frame_cnt_next = '0;
                    state_next     = (SKIP_FRAMES == 0) ? ACTIVE : SKIP;
                end
            end
            SKIP: begin
                if (vs_rise) begin
                    frame_cnt_next = frame_cnt + 8'd1;
                    if ({1'b0, frame_cnt} + 9'd1 == SKIP_W) begin
                        state_next = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                state_next = ACTIVE;
            end
            default: begin
                state_next = WAIT_SYNC;
            end
        endcase
    end

    // A line closes either on an href fall or when vsync cuts it short; the
    // frame check then sees the line count including that closing line.
    always_comb begin
        line_trunc   = (state == ACTIVE) & vs_rise & data_href;
        line_close   = line_trunc | ((state == ACTIVE) & href_fall & line_open);
        line_bad     = line_trunc | byte_phase | (pix_cnt != H_W);
        line_cnt_upd = line_close ? sat_inc(line_cnt) : line_cnt;
        frame_close  = (state == ACTIVE) & vs_rise & (line_cnt_upd != 12'd0);
        frame_bad    = (line_cnt_upd != V_W);
    end

    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d     <= 1'b0;
            href_d      <= 1'b0;
            byte_phase  <= 1'b0;
            line_open   <= 1'b0;
            high_byte   <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            vsync_d     <= data_vsync;
            href_d      <= data_href;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;

            if (accept) begin
                line_open <= 1'b1;
                if (!byte_phase) begin
                    high_byte  <= source_data;
                    byte_phase <= 1'b1;
                end else begin
                    pixel_data  <= {high_byte, source_data};
                    pixel_valid <= 1'b1;
                    pixel_x     <= pix_cnt;
                    pixel_y     <= line_cnt;
                    frame_start <= (pix_cnt == 12'd0) && (line_cnt == 12'd0);
                    byte_phase  <= 1'b0;
                    pix_cnt     <= sat_inc(pix_cnt);
                end
            end

            // A dangling high byte is simply dropped when the line closes.
            if (line_close) begin
                line_end   <= 1'b1;
                frame_err  <= line_bad;
                pix_cnt    <= '0;
                byte_phase <= 1'b0;
                line_open  <= 1'b0;
                line_cnt   <= line_cnt_upd;
            end

            if ((state == ACTIVE) && vs_rise) begin
                pix_cnt    <= '0;
                byte_phase <= 1'b0;
                line_open  <= 1'b0;
            end

            if (frame_close) begin
                frame_done <= 1'b1;
                line_cnt   <= '0;
                if (frame_bad) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
